// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Default Q-format, complex sample layout, read FSM encoding and index bit reversal.
package fft_pkg;
    localparam int DEF_INTEGER_SIZE = 6;
    localparam int DEF_FRACT_SIZE   = 12;
    localparam int DEF_DATA_WIDTH   = DEF_INTEGER_SIZE + DEF_FRACT_SIZE;
    localparam int MAX_LOG2N        = 10;

    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] r;
        logic signed [DEF_DATA_WIDTH-1:0] i;
    } cplx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    // Reverses the low log2n bits of v; upper bits return zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                    input int log2n);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_LOG2N; b++) begin
            if (b < log2n) r[b] = v[log2n-1-b];
        end
        return r;
    endfunction
endpackage

// File: rtl/fft_output_reorder_ram.sv
// Two-bank complex sample memory: one synchronous write port, one combinational read port.
// Bank select is the address MSB, so both banks share a single array.
module reorder_bank_ram #(
    parameter int WIDTH = 36,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);
    logic [WIDTH-1:0] mem_q [2**(AW+1)];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[{wr_bank, wr_addr}] <= wr_dat;
    end

    assign rd_dat = mem_q[{rd_bank, rd_addr}];
endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder of bit-reversed SDF FFT output into natural bin order; first bin appears
// one cycle after a frame completes, out_* hold while out_ready is low, full banks drop input.
module fft_output_reorder
    import fft_pkg::*;
#(
    parameter int INTEGER_SIZE = DEF_INTEGER_SIZE,
    parameter int FRACT_SIZE   = DEF_FRACT_SIZE,
    parameter int NFFT         = 64,
    localparam int DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE,
    localparam int LOG2N       = $clog2(NFFT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic signed [DATA_WIDTH-1:0] serial_in_r,
    input  logic signed [DATA_WIDTH-1:0] serial_in_i,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] serial_out_r,
    output logic signed [DATA_WIDTH-1:0] serial_out_i,
    output logic [LOG2N-1:0]             out_index,
    output logic                         out_last,
    output logic                         overflow,
    output logic                         sync_err
);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(NFFT - 1);

    logic [LOG2N-1:0]             wcnt_q, wcnt_d, rcnt_q, rcnt_d, out_index_q, out_index_d;
    logic                         wbank_q, wbank_d, rbank_q, rbank_d;
    logic [1:0]                   full_q, full_d;
    logic                         overflow_q, overflow_d, sync_err_q, sync_err_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
    rd_state_t                    state_q, state_d;

    logic                         wr_ok, wr_en, load, rel, rd_bank;
    logic [LOG2N-1:0]             wr_addr, rd_addr;
    logic [MAX_LOG2N-1:0]         br;
    logic [2*DATA_WIDTH-1:0]      rd_dat;

    reorder_bank_ram #(.WIDTH(2*DATA_WIDTH), .AW(LOG2N)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wbank_q),
        .wr_addr (wr_addr),
        .wr_dat  ({serial_in_r, serial_in_i}),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        full_d      = full_q;
        overflow_d  = overflow_q;
        sync_err_d  = sync_err_q;
        state_d     = state_q;
        rbank_d     = rbank_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        rd_bank     = rbank_q;
        rd_addr     = '0;
        load        = 1'b0;
        rel         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    load    = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (out_index_q == LAST) begin
                        rel             = 1'b1;
                        full_d[rbank_q] = 1'b0;
                        rbank_d         = ~rbank_q;
                        if (full_q[~rbank_q]) begin
                            load    = 1'b1;
                            rd_bank = ~rbank_q;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = ST_IDLE;
                        end
                    end else begin
                        load    = 1'b1;
                        rd_addr = rcnt_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_index_d = rd_addr;
            rcnt_d      = rd_addr + LOG2N'(1);
            out_r_d     = rd_dat[2*DATA_WIDTH-1:DATA_WIDTH];
            out_i_d     = rd_dat[DATA_WIDTH-1:0];
        end

        // A bank drained on this very edge may take its new first sample, which keeps
        // continuous input with out_ready high from ever overflowing.
        wr_ok   = ~full_q[wbank_q] | (rel & (rbank_q == wbank_q));
        wr_en   = in_valid & wr_ok;
        br      = bitrev(MAX_LOG2N'(wcnt_q), LOG2N);
        wr_addr = in_sof ? '0 : br[LOG2N-1:0];

        if (in_valid && !wr_ok) begin
            overflow_d = 1'b1;
        end else if (wr_en) begin
            if (in_sof) begin
                if (wcnt_q != '0) sync_err_d = 1'b1;
                wcnt_d = LOG2N'(1);
            end else if (wcnt_q == LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
            end else begin
                wcnt_d = wcnt_q + LOG2N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            wbank_q     <= 1'b0;
            full_q      <= '0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            state_q     <= ST_IDLE;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            sync_err_q  <= sync_err_d;
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign serial_out_r = out_r_q;
    assign serial_out_i = out_i_q;
    assign out_index    = out_index_q;
    assign out_last     = out_valid_q && (out_index_q == LAST);
    assign overflow     = overflow_q;
    assign sync_err     = sync_err_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder: an NFFT=8 instance for the frame-level corner cases
// and an NFFT=64 instance for continuous back-to-back streaming.
module tb_fft_output_reorder;
    import fft_pkg::*;

    localparam int DW = 18;

    typedef struct {
        cplx_t d;
        int    idx;
        bit    last;
    } exp_t;

    typedef struct {
        int in_w;
        bit sof;
        int exp_k;
        bit exp_last;
    } vec_t;

    logic clk;
    logic rst, in_valid, in_sof, out_ready;
    logic signed [DW-1:0] in_r, in_i;
    logic out_valid, out_last, overflow, sync_err;
    logic signed [DW-1:0] out_r, out_i;
    logic [2:0] out_index;

    logic v64, sof64;
    logic signed [DW-1:0] r64, i64;
    logic ov64, olast64, ovf64, serr64;
    logic signed [DW-1:0] or64, oi64;
    logic [5:0] oidx64;

    int total = 0;
    int bad = 0;
    exp_t sbq[$];
    exp_t q64[$];
    exp_t e8, e64;
    bit mon_en = 0;
    bit hold_pend = 0;
    cplx_t held_d;
    int held_idx;
    int run64 = 0;
    int max64 = 0;

    fft_output_reorder #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .serial_in_r(in_r), .serial_in_i(in_i), .out_ready(out_ready),
        .out_valid(out_valid), .serial_out_r(out_r), .serial_out_i(out_i),
        .out_index(out_index), .out_last(out_last), .overflow(overflow), .sync_err(sync_err)
    );

    fft_output_reorder #(.INTEGER_SIZE(6), .FRACT_SIZE(12), .NFFT(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_sof(sof64),
        .serial_in_r(r64), .serial_in_i(i64), .out_ready(1'b1),
        .out_valid(ov64), .serial_out_r(or64), .serial_out_i(oi64),
        .out_index(oidx64), .out_last(olast64), .overflow(ovf64), .sync_err(serr64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int tb_bitrev(input int v, input int nb);
        int r = 0;
        for (int j = 0; j < nb; j++) r = (r << 1) | ((v >> j) & 1);
        return r;
    endfunction

    // NFFT=8 output checker: pops on every handshake, and verifies held outputs under backpressure.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_pend) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_r", int'(out_r), int'(held_d.r));
                chk("hold_i", int'(out_i), int'(held_d.i));
                chk("hold_idx", int'(out_index), held_idx);
            end
            hold_pend = 0;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got bin %0d r=%0d, expected no output", out_index, out_r);
                end else begin
                    e8 = sbq.pop_front();
                    chk("bin_r", int'(out_r), int'(e8.d.r));
                    chk("bin_i", int'(out_i), int'(e8.d.i));
                    chk("bin_idx", int'(out_index), e8.idx);
                    chk("bin_last", int'(out_last), int'(e8.last));
                end
            end else if (out_valid) begin
                hold_pend = 1;
                held_d.r = out_r;
                held_d.i = out_i;
                held_idx = int'(out_index);
            end
        end
    end

    // NFFT=64 checker: always ready, tracks longest run of consecutive valid cycles.
    always @(negedge clk) begin
        if (ov64) begin
            run64++;
            if (run64 > max64) max64 = run64;
            if (q64.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out64: got bin %0d, expected no output", oidx64);
            end else begin
                e64 = q64.pop_front();
                chk("b2b_r", int'(or64), int'(e64.d.r));
                chk("b2b_i", int'(oi64), int'(e64.d.i));
                chk("b2b_idx", int'(oidx64), e64.idx);
                chk("b2b_last", int'(olast64), int'(e64.last));
            end
        end else begin
            run64 = 0;
        end
    end

    task automatic send(input int v, input bit sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_r     = DW'(v);
        in_i     = DW'(-v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Drives one frame so that natural-order bin k carries value base+k.
    task automatic send_frame8(input int base, input bit push);
        exp_t e;
        if (push) begin
            for (int k = 0; k < 8; k++) begin
                e.d.r  = DW'(base + k);
                e.d.i  = DW'(-(base + k));
                e.idx  = k;
                e.last = (k == 7);
                sbq.push_back(e);
            end
        end
        for (int p = 0; p < 8; p++) send(base + tb_bitrev(p, 3), p == 0);
    endtask

    task automatic drain(input bit bp, input int budget, input string nm);
        int c = 0;
        while ((sbq.size() != 0 || out_valid) && c < budget) begin
            out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            @(posedge clk);
            #1;
            c++;
        end
        out_ready = 1'b1;
        chk({nm, "_left_in_queue"}, sbq.size(), 0);
        chk({nm, "_valid_after"}, int'(out_valid), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, int'(out_valid), 0);
        chk({nm, "_r"}, int'(out_r), 0);
        chk({nm, "_i"}, int'(out_i), 0);
        chk({nm, "_idx"}, int'(out_index), 0);
        chk({nm, "_last"}, int'(out_last), 0);
        chk({nm, "_overflow"}, int'(overflow), 0);
        chk({nm, "_sync_err"}, int'(sync_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        exp_t e;
        int c;

        tbl[0] = '{0, 1'b1, 0, 1'b0};
        tbl[1] = '{1, 1'b0, 4, 1'b0};
        tbl[2] = '{2, 1'b0, 2, 1'b0};
        tbl[3] = '{3, 1'b0, 6, 1'b0};
        tbl[4] = '{4, 1'b0, 1, 1'b0};
        tbl[5] = '{5, 1'b0, 5, 1'b0};
        tbl[6] = '{6, 1'b0, 3, 1'b0};
        tbl[7] = '{7, 1'b0, 7, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b0;
        v64 = 1'b0; sof64 = 1'b0; r64 = '0; i64 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        chk("reset64_valid", int'(ov64), 0);
        mon_en = 1;

        // Back-to-back: three continuous NFFT=64 frames
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 64; k++) begin
                e.d.r = DW'(f * 64 + k + 1000);
                e.d.i = DW'(-(f * 64 + k + 1000));
                e.idx = k;
                e.last = (k == 63);
                q64.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 64; p++) begin
                v64 = 1'b1;
                sof64 = (p == 0);
                r64 = DW'(f * 64 + tb_bitrev(p, 6) + 1000);
                i64 = -r64;
                @(posedge clk);
                #1;
            end
        end
        v64 = 1'b0;
        sof64 = 1'b0;
        c = 0;
        while ((q64.size() != 0 || ov64) && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("b2b_valid_run", max64, 192);
        chk("b2b_left_in_queue", q64.size(), 0);
        chk("b2b_overflow", int'(ovf64), 0);
        chk("b2b_sync_err", int'(serr64), 0);

        // Single frame from the table, with first-output latency
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            e.d.r = DW'(tbl[n].exp_k);
            e.d.i = DW'(-tbl[n].exp_k);
            e.idx = n;
            e.last = tbl[n].exp_last;
            sbq.push_back(e);
            send(tbl[n].in_w, tbl[n].sof);
        end
        @(negedge clk);
        chk("latency_same_cycle_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("latency_next_cycle_valid", int'(out_valid), 1);
        drain(0, 100, "single");

        // Backpressure 1,0,0,1 during readout
        out_ready = 1'b0;
        send_frame8(20, 1);
        drain(1, 200, "backpressure");

        // Resync: in_sof arrives at w=5
        for (int w = 0; w < 5; w++) send(500 + w, w == 0);
        chk("resync_err_before", int'(sync_err), 0);
        send_frame8(600, 1);
        chk("resync_err_set", int'(sync_err), 1);
        drain(0, 100, "resync");

        // Overflow: two frames held, third frame dropped
        out_ready = 1'b0;
        send_frame8(700, 1);
        send_frame8(800, 1);
        chk("overflow_before_frame3", int'(overflow), 0);
        send(900, 1);
        chk("overflow_on_frame3", int'(overflow), 1);
        for (int p = 1; p < 8; p++) send(900 + p, 0);
        drain(0, 200, "overflow");
        chk("overflow_sticky", int'(overflow), 1);

        // Reset during readout at k=3
        send_frame8(1000, 1);
        c = 0;
        while (!(out_valid && out_index == 3'd3) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("reset_reached_k3", int'(out_index), 3);
        mon_en = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        hold_pend = 0;
        @(negedge clk);
        chk_zero("midreset");
        mon_en = 1;
        send_frame8(1100, 1);
        drain(0, 100, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
